// File: rtl/sad_pkg.sv
// sad_pkg: shared SAD sizing constants and controller state encodings
package sad_pkg;
  localparam int N_PIX = 256;
  localparam int PIX_W = 8;
  localparam int I_W = $clog2(N_PIX) + 1;
  localparam int SUM_W = PIX_W + $clog2(N_PIX);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} sad_state_t;
endpackage

// File: rtl/sad_absdiff.sv
// sad_absdiff: combinational unsigned |a-b|
module sad_absdiff
  import sad_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] d
);
  logic [PIX_W:0] diff;
  // one extra bit carries the sign; negate the low bits when a < b
  always_comb begin
    diff = {1'b0, a} - {1'b0, b};
    d = diff[PIX_W] ? PIX_W'(-diff[PIX_W-1:0]) : diff[PIX_W-1:0];
  end
endmodule

// File: rtl/sad_datapath.sv
// sad_datapath: SAD index/accumulator/result registers; SAD_MINTRACK_EN adds best-SAD tracking
module sad_datapath
  import sad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             sum_clr,
  input  logic             sum_ld,
  input  logic             AB_rd,
  input  logic             sadreg_clr,
  input  logic             sadreg_ld,
  output logic             i_lt_256,
  output logic [I_W-2:0]   mem_addr,
  output logic             mem_rd,
  input  logic [PIX_W-1:0] a_data,
  input  logic [PIX_W-1:0] b_data,
  output logic [SUM_W-1:0] sad,
`ifdef SAD_MINTRACK_EN
  output logic [SUM_W-1:0] best_sad,
  output logic [7:0]       best_idx,
  output logic [7:0]       run_cnt,
`endif
  output logic             sad_valid
);
  logic [I_W-1:0]   idx;
  logic [SUM_W-1:0] acc;
  logic [PIX_W-1:0] ad;
  sad_absdiff u_absdiff (.a(a_data), .b(b_data), .d(ad));
  assign i_lt_256 = idx < I_W'(N_PIX);
  assign mem_addr = idx[I_W-2:0];
  assign mem_rd = AB_rd & i_lt_256;
  // pixel index, saturating at N_PIX so stray increments cannot wrap
  always_ff @(posedge clk)
    if (rst || i_clr) idx <= '0;
    else if (i_inc && i_lt_256) idx <= idx + I_W'(1);
  // |A-B| accumulator, frozen once the index has run past the block
  always_ff @(posedge clk)
    if (rst || sum_clr) acc <= '0;
    else if (sum_ld && i_lt_256) acc <= acc + SUM_W'(ad);
  // result register captures the pre-update accumulator
  always_ff @(posedge clk)
    if (rst || sadreg_clr) begin
      sad <= '0;
      sad_valid <= 1'b0;
    end else if (sadreg_ld) begin
      sad <= acc;
      sad_valid <= 1'b1;
    end
`ifdef SAD_MINTRACK_EN
  // smallest SAD seen across runs; ties keep the earlier run index
  always_ff @(posedge clk)
    if (rst) begin
      best_sad <= '1;
      best_idx <= '0;
      run_cnt <= '0;
    end else if (sadreg_ld) begin
      if (acc < best_sad) begin
        best_sad <= acc;
        best_idx <= run_cnt;
      end
      run_cnt <= run_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_sad_datapath.sv
// tb_sad_datapath: directed scoreboard bench for sad_datapath (SAD_MINTRACK_EN enables tracking checks)
module tb_sad_datapath;
  import sad_pkg::*;
  logic clk = 1'b0;
  logic rst, i_clr, i_inc, sum_clr, sum_ld, AB_rd, sadreg_clr, sadreg_ld;
  logic i_lt_256, mem_rd, sad_valid;
  logic [I_W-2:0] mem_addr;
  logic [PIX_W-1:0] a_data, b_data;
  logic [SUM_W-1:0] sad;
`ifdef SAD_MINTRACK_EN
  logic [SUM_W-1:0] best_sad;
  logic [7:0] best_idx, run_cnt;
`endif
  logic [PIX_W-1:0] mem_a [N_PIX];
  logic [PIX_W-1:0] mem_b [N_PIX];
  int checks = 0;
  int errors = 0;
  int exp_q [$];

  always #5 clk = ~clk;
  assign a_data = mem_a[mem_addr];
  assign b_data = mem_b[mem_addr];

  sad_datapath dut (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_inc(i_inc), .sum_clr(sum_clr), .sum_ld(sum_ld),
    .AB_rd(AB_rd), .sadreg_clr(sadreg_clr), .sadreg_ld(sadreg_ld), .i_lt_256(i_lt_256),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .a_data(a_data), .b_data(b_data), .sad(sad),
`ifdef SAD_MINTRACK_EN
    .best_sad(best_sad), .best_idx(best_idx), .run_cnt(run_cnt),
`endif
    .sad_valid(sad_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_sad(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else check(tag, 32'(sad), 32'(exp_q.pop_front()));
  endtask

  task automatic idle();
    {i_clr, i_inc, sum_clr, sum_ld, AB_rd, sadreg_clr, sadreg_ld} = '0;
  endtask

  function automatic int model_sum();
    int s = 0;
    for (int k = 0; k < N_PIX; k++)
      s += (mem_a[k] > mem_b[k]) ? int'(mem_a[k]) - int'(mem_b[k]) : int'(mem_b[k]) - int'(mem_a[k]);
    return s;
  endfunction

  task automatic run_block(input string tag);
    sad_state_t st = S1;
    sad_state_t nxt;
    int cyc = 0;
    exp_q.push_back(model_sum());
    while (st != S0 && cyc < 2000) begin
      i_clr = st == S1;
      sum_clr = st == S1;
      sadreg_clr = st == S1;
      sum_ld = st == S3;
      i_inc = st == S3;
      AB_rd = st == S3;
      sadreg_ld = st == S4;
      case (st)
        S1: nxt = S2;
        S2: nxt = i_lt_256 ? S3 : S4;
        S3: nxt = S2;
        default: nxt = S0;
      endcase
      step();
      cyc++;
      st = nxt;
    end
    idle();
    check({tag, "_cycles"}, 32'(cyc), 32'(2 * N_PIX + 3));
    check({tag, "_valid"}, 32'(sad_valid), 32'd1);
    check_sad({tag, "_sad"});
  endtask

  // pulse one strobe set for a single cycle
  task automatic pulse_sadreg_ld();
    sadreg_ld = 1'b1;
    step();
    sadreg_ld = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    for (int k = 0; k < N_PIX; k++) begin
      mem_a[k] = PIX_W'(k);
      mem_b[k] = '0;
    end
    step();
    step();
    rst = 1'b0;
    check("rst_sad", 32'(sad), 32'd0);
    check("rst_valid", 32'(sad_valid), 32'd0);
    check("rst_lt", 32'(i_lt_256), 32'd1);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_rd", 32'(mem_rd), 32'd0);

    // partial accumulation, capture mid-run, then reset while strobes are active
    i_clr = 1'b1;
    sum_clr = 1'b1;
    step();
    idle();
    exp_q.push_back(1176);
    sum_ld = 1'b1;
    i_inc = 1'b1;
    AB_rd = 1'b1;
    for (int k = 0; k < 50; k++) begin
      sadreg_ld = k == 49;
      step();
    end
    sadreg_ld = 1'b0;
    check("mid_rd", 32'(mem_rd), 32'd1);
    check_sad("mid_sad");
    check("mid_valid", 32'(sad_valid), 32'd1);
    AB_rd = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("rst2_sad", 32'(sad), 32'd0);
    check("rst2_valid", 32'(sad_valid), 32'd0);
    check("rst2_lt", 32'(i_lt_256), 32'd1);
    check("rst2_rd", 32'(mem_rd), 32'd0);
    check("rst2_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    idle();
    exp_q.push_back(0);
    pulse_sadreg_ld();
    check_sad("rst2_acc_discarded");

    // full blocks
    run_block("ramp");
    for (int k = 0; k < N_PIX; k++) mem_a[k] = 8'hff;
    run_block("max");
    for (int k = 0; k < N_PIX; k++) begin
      mem_a[k] = PIX_W'($urandom_range(0, 255));
      mem_b[k] = mem_a[k];
    end
    run_block("equal");
    for (int k = 0; k < N_PIX; k++) begin
      mem_a[k] = PIX_W'($urandom_range(0, 255));
      mem_b[k] = PIX_W'($urandom_range(0, 255));
    end
    run_block("random");

    // stray increments past the block end
    mem_a[0] = 8'd9;
    mem_b[0] = 8'd2;
    i_clr = 1'b1;
    sum_clr = 1'b1;
    step();
    idle();
    sum_ld = 1'b1;
    step();
    sum_ld = 1'b0;
    i_inc = 1'b1;
    for (int k = 0; k < 300; k++) step();
    i_inc = 1'b0;
    AB_rd = 1'b1;
    check("sat_lt", 32'(i_lt_256), 32'd0);
    check("sat_addr", 32'(mem_addr), 32'd0);
    check("sat_rd", 32'(mem_rd), 32'd0);
    AB_rd = 1'b0;
    sum_ld = 1'b1;
    step();
    sum_ld = 1'b0;
    exp_q.push_back(7);
    pulse_sadreg_ld();
    check_sad("sat_acc_hold");

    // simultaneous clear and load/increment strobes
    i_clr = 1'b1;
    sum_clr = 1'b1;
    step();
    idle();
    sum_ld = 1'b1;
    step();
    sum_clr = 1'b1;
    step();
    idle();
    exp_q.push_back(0);
    pulse_sadreg_ld();
    check_sad("clr_sum_wins");
    sum_ld = 1'b1;
    step();
    sum_ld = 1'b0;
    exp_q.push_back(7);
    pulse_sadreg_ld();
    check_sad("reload_sad");
    check("reload_valid", 32'(sad_valid), 32'd1);
    i_inc = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("inc_addr", 32'(mem_addr), 32'd3);
    i_clr = 1'b1;
    step();
    idle();
    check("clr_idx_wins", 32'(mem_addr), 32'd0);
    sadreg_clr = 1'b1;
    sadreg_ld = 1'b1;
    step();
    idle();
    check("clr_sadreg_sad", 32'(sad), 32'd0);
    check("clr_sadreg_valid", 32'(sad_valid), 32'd0);

`ifdef SAD_MINTRACK_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mt_rst_best", 32'(best_sad), 32'hffff);
    check("mt_rst_cnt", 32'(run_cnt), 32'd0);
    mem_a[0] = 8'd100;
    mem_b[0] = 8'd0;
    foreach (exp_q[j]) exp_q.delete(j);
    for (int r = 0; r < 4; r++) begin
      int loads;
      loads = (r == 0) ? 5 : (r == 3) ? 7 : 3;
      sum_clr = 1'b1;
      sadreg_clr = 1'b1;
      step();
      idle();
      sum_ld = 1'b1;
      for (int k = 0; k < loads; k++) step();
      sum_ld = 1'b0;
      pulse_sadreg_ld();
      check("mt_run_sad", 32'(sad), 32'(loads * 100));
    end
    check("mt_best_sad", 32'(best_sad), 32'd300);
    check("mt_best_idx", 32'(best_idx), 32'd1);
    check("mt_run_cnt", 32'(run_cnt), 32'd4);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
